rf_wb_scheduler: RTL

RF_WB_SCHEDULER -- requirements
Module: rf_wb_scheduler

---
 rtl/rf_wb_scheduler.sv | 78 +++++++
 1 files changed

// File: rtl/rf_wb_scheduler.sv
// rf_wb_scheduler: arbitrates ALU/LSU writebacks onto one register-file write port and keeps a busy scoreboard.
// Ports:
//   rf_clk, rf_ares                  clock, asynchronous active-high reset
//   alu_valid/alu_rd/alu_data, alu_ready   ALU writeback request and grant
//   lsu_valid/lsu_rd/lsu_data, lsu_ready   LSU writeback request and grant
//   iss_valid/iss_rd, iss_ready      issue-stage destination reservation
//   ra_chk/rb_chk, ra_busy/rb_busy   source busy lookups
//   wb_en/wb_addr/wb_data            registered register-file write port
// Macro RF_WB_RR_EN selects round-robin arbitration; default is fixed priority (LSU over ALU).
module rf_wb_scheduler #(
   parameter int REG_DATA_W = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  rf_clk,
   input  logic                  rf_ares,
   input  logic                  alu_valid,
   input  logic [ADDR_WIDTH-1:0] alu_rd,
   input  logic [REG_DATA_W-1:0] alu_data,
   output logic                  alu_ready,
   input  logic                  lsu_valid,
   input  logic [ADDR_WIDTH-1:0] lsu_rd,
   input  logic [REG_DATA_W-1:0] lsu_data,
   output logic                  lsu_ready,
   input  logic                  iss_valid,
   input  logic [ADDR_WIDTH-1:0] iss_rd,
   output logic                  iss_ready,
   input  logic [ADDR_WIDTH-1:0] ra_chk,
   input  logic [ADDR_WIDTH-1:0] rb_chk,
   output logic                  ra_busy,
   output logic                  rb_busy,
   output logic                  wb_en,
   output logic [ADDR_WIDTH-1:0] wb_addr,
   output logic [REG_DATA_W-1:0] wb_data
);
   localparam int NREG = 1 << ADDR_WIDTH;
   logic [NREG-1:0]       busy, busy_nxt;
   logic                  acc, set_en;
   logic [ADDR_WIDTH-1:0] sel_rd;
   logic [REG_DATA_W-1:0] sel_data;
`ifdef RF_WB_RR_EN
   // last_lsu=0 means ALU was granted last, so LSU wins the first contention
   logic last_lsu;
   assign lsu_ready = !rf_ares && lsu_valid && (!alu_valid || !last_lsu);
   assign alu_ready = !rf_ares && alu_valid && !lsu_ready;
   always_ff @(posedge rf_clk or posedge rf_ares)
      if (rf_ares) last_lsu <= 1'b0;
      else if (acc) last_lsu <= lsu_ready;
`else
   assign lsu_ready = !rf_ares && lsu_valid;
   assign alu_ready = !rf_ares && alu_valid && !lsu_valid;
`endif
   assign acc      = alu_ready || lsu_ready;
   assign sel_rd   = lsu_ready ? lsu_rd : alu_rd;
   assign sel_data = lsu_ready ? lsu_data : alu_data;
   assign iss_ready = !rf_ares && (iss_rd == '0 || !busy[iss_rd]);
   assign set_en    = iss_valid && iss_ready && iss_rd != '0;
   assign ra_busy   = busy[ra_chk];
   assign rb_busy   = busy[rb_chk];
   // clear first so a same-index reservation overrides it
   always_comb begin
      busy_nxt = busy;
      if (wb_en) busy_nxt[wb_addr] = 1'b0;
      if (set_en) busy_nxt[iss_rd] = 1'b1;
      busy_nxt[0] = 1'b0;
   end
   always_ff @(posedge rf_clk or posedge rf_ares)
      if (rf_ares) begin
         busy    <= '0;
         wb_en   <= 1'b0;
         wb_addr <= '0;
         wb_data <= '0;
      end else begin
         busy    <= busy_nxt;
         wb_en   <= acc && sel_rd != '0;
         wb_addr <= acc ? sel_rd : wb_addr;
         wb_data <= acc ? sel_data : wb_data;
      end
endmodule
